pc_fetch_queue: RTL
===================

Name: pc_fetch_queue

Overview:
- Parametrised successor to the single-register PC: a fetch front-end that generates PCs and issues pipelined requests to instruction memory with a req/gnt handshake.
- Accepts in-order responses of any latency and buffers {pc, instr} pairs in a QDEPTH-entry prefetch ring for the decode stage.
- Applies flush and branch redirects cleanly, discarding stale in-flight responses.
- Sits between the controller/branch unit and the IF/ID pipeline register.

Parameters:
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- STEP, 4, PC increment per fetch.
- QDEPTH, 4, prefetch entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  controller redirect (exception/eret); highest priority.
- flush_pc  in  ADDR_W  flush target.
- branch_valid  in  1  branch-unit redirect.
- branch_target  in  ADDR_W  branch target.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request address (= fetch_pc).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in order, at most one per cycle.
- imem_rdata  in  DATA_W  instruction data.
- inst_valid  out  1  head entry available.
- inst_pc  out  ADDR_W  PC of head entry.
- inst_data  out  DATA_W  instruction of head entry.
- inst_ready  in  1  decode accepts head (low = stall).

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc<=RESET_PC; ring pointers and drop_cnt<=0; run<=0.
  - While rst or run=0: imem_req=0 and inst_valid=0.
  - run<=1 on the first edge after rst deasserts, so the first request appears one cycle after reset release.
  - Reset mid-operation abandons in-flight responses; memory is reset together with this block.
- Ring: three pointers, wr (alloc), fill, rd, each log2(QDEPTH)+1 bits with wrap bit.
  - alloc = wr-rd; an entry is filled iff it lies in [rd, fill).
- Issue: imem_req = run & !redirect & (alloc + drop_cnt < QDEPTH).
  - On req&gnt: entry[wr].pc<=fetch_pc, wr++, fetch_pc<=fetch_pc+STEP (mod 2^ADDR_W, wraps silently).
  - imem_addr holds fetch_pc stable while req&!gnt.
- Response: on imem_rvalid:
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Else: entry[fill].data<=imem_rdata, fill++.
  - A response becomes visible at inst_valid the cycle after imem_rvalid; there is no bypass.
- Output: inst_valid = run & !redirect & (fill!=rd); inst_pc/inst_data = entry[rd].
  - Pop (rd++) when inst_valid & inst_ready.
  - Outputs are held unchanged while stalled.
- Redirect = flush | branch_valid.
  - Target = flush ? flush_pc : branch_target; flush wins if both are asserted.
  - fetch_pc<=target.
  - drop_cnt <= drop_cnt + (wr-fill) - (imem_rvalid ? 1 : 0), i.e. all requests still owed.
  - wr<=fill<=rd<=0.
  - imem_req and inst_valid are forced low in the redirect cycle, so no issue and no pop occur.
  - A response arriving in the redirect cycle is always dropped.
  - First request to the target occurs the cycle after the redirect.
- Simultaneous issue+response+pop in one cycle: all three pointers update independently; alloc is computed from pre-edge values.
- Full: alloc + drop_cnt == QDEPTH blocks requests, which bounds outstanding requests so every response has a slot. The ring never overflows, and imem_rvalid with no owed request is a protocol error (assertion).
- Empty: inst_valid=0; inst_pc/inst_data are don't-care.

Decomposition:
- Shared package (defines): ZeroWord, RstEnable, default RESET_PC, STEP, and a fetch-entry typedef {pc, data}.
- Sub-module pc_fq_ring: storage array plus wr/fill/rd pointers, with alloc/full/valid outputs.
- Top level holds fetch_pc, run, drop_cnt, issue logic and redirect logic.

Test Plan:
- Reset release, gnt=1, rvalid one cycle later, ready=1: imem_addr 0x0,0x4,0x8…; inst_pc 0x0 is valid 2 cycles after the first request, then one instruction per cycle.
- ready=0 continuously, QDEPTH=4: exactly 4 grants (0x0–0xC), then imem_req=0; inst_pc holds 0x0; after ready=1, requests resume at 0x10.
- gnt held low 3 cycles: imem_addr is stable at 0x4 and fetch_pc does not advance.
- Branch to 0x100 with 3 requests outstanding (0x8,0xC,0x10) and response latency 3: those 3 responses are dropped; next inst_pc=0x100 with data from the 4th response.
- flush (flush_pc 0xBFC0_0380) and branch_valid (0x200) in the same cycle: next imem_addr=0xBFC0_0380.
- fetch_pc=0xFFFF_FFFC with a grant: next imem_addr=0x0000_0000; rst asserted mid-stream: imem_req=0, inst_valid=0 next cycle, then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_queue_pkg.sv
// Shared constants and types for the PC fetch queue front-end.
// Imported by the fetch queue top level and its prefetch ring.
package pc_fetch_queue_pkg;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic        RstEnable  = 1'b1;
    localparam logic [31:0] DefResetPc = 32'h0000_0000;
    localparam int          DefStep    = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/pc_fq_ring.sv
// Prefetch ring: entries are allocated at request time (pc) and filled at response time (data).
// Three wrap-bit pointers: wr allocates, fill completes, rd pops; [rd, fill) holds valid entries.
module pc_fq_ring
    import pc_fetch_queue_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_push,
    input  logic [ADDR_W-1:0]         i_push_pc,
    input  logic                      i_fill,
    input  logic [DATA_W-1:0]         i_fill_data,
    input  logic                      i_pop,
    output logic [$clog2(QDEPTH):0]   o_alloc,
    output logic [$clog2(QDEPTH):0]   o_owed,
    output logic                      o_full,
    output logic                      o_valid,
    output logic [ADDR_W-1:0]         o_head_pc,
    output logic [DATA_W-1:0]         o_head_data
);

    localparam int IDX_W = $clog2(QDEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  r_wr;
    logic [PTR_W-1:0]  r_fill;
    logic [PTR_W-1:0]  r_rd;
    logic [ADDR_W-1:0] r_pc   [QDEPTH];
    logic [DATA_W-1:0] r_data [QDEPTH];

    always_ff @(posedge clk) begin
        if (i_push) r_pc[r_wr[IDX_W-1:0]] <= i_push_pc;
        if (i_fill) r_data[r_fill[IDX_W-1:0]] <= i_fill_data;
    end

    // Pointers move independently so issue, fill and pop can all happen in one cycle.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || i_clear) begin
            r_wr   <= PTR_W'(ZeroWord);
            r_fill <= PTR_W'(ZeroWord);
            r_rd   <= PTR_W'(ZeroWord);
        end else begin
            if (i_push) r_wr   <= r_wr + PTR_W'(1);
            if (i_fill) r_fill <= r_fill + PTR_W'(1);
            if (i_pop)  r_rd   <= r_rd + PTR_W'(1);
        end
    end

    assign o_alloc     = r_wr - r_rd;
    assign o_owed      = r_wr - r_fill;
    assign o_full      = (o_alloc == PTR_W'(QDEPTH));
    assign o_valid     = (r_fill != r_rd);
    assign o_head_pc   = r_pc[r_rd[IDX_W-1:0]];
    assign o_head_data = r_data[r_rd[IDX_W-1:0]];

endmodule

// File: rtl/pc_fetch_queue.sv
// Fetch front-end: generates PCs, issues pipelined req/gnt requests to instruction memory,
// buffers in-order responses for decode and discards stale responses after redirects.
module pc_fetch_queue
    import pc_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DefResetPc),
    parameter int                STEP     = DefStep,
    parameter int                QDEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_pc,
    input  logic              i_branch_valid,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic              o_inst_valid,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic [DATA_W-1:0] o_inst_data,
    input  logic              i_inst_ready
);

    localparam int PTR_W = $clog2(QDEPTH) + 1;

    logic              r_run;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [PTR_W-1:0]  r_drop_cnt;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic              w_active;
    logic              w_room;
    logic              w_issue;
    logic              w_fill;
    logic              w_pop;
    logic [PTR_W-1:0]  w_alloc;
    logic [PTR_W-1:0]  w_owed;
    logic [PTR_W:0]    w_owed_total;
    logic              w_full;
    logic              w_ring_valid;

    assign w_redirect = i_flush | i_branch_valid;
    assign w_target   = i_flush ? i_flush_pc : i_branch_target;
    assign w_active   = r_run & (rst != RstEnable) & ~w_redirect;

    // Dropped responses still need a slot's worth of budget, so they count against the ring.
    assign w_room       = ~w_full & (({1'b0, w_alloc} + {1'b0, r_drop_cnt}) < (PTR_W+1)'(QDEPTH));
    assign w_owed_total = {1'b0, r_drop_cnt} + {1'b0, w_owed};

    assign o_imem_req   = w_active & w_room;
    assign o_imem_addr  = r_fetch_pc;
    assign w_issue      = o_imem_req & i_imem_gnt;
    assign w_fill       = i_imem_rvalid & w_active & (r_drop_cnt == '0);
    assign o_inst_valid = w_active & w_ring_valid;
    assign w_pop        = o_inst_valid & i_inst_ready;

    pc_fq_ring #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .QDEPTH (QDEPTH)
    ) u_ring (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_redirect),
        .i_push      (w_issue),
        .i_push_pc   (r_fetch_pc),
        .i_fill      (w_fill),
        .i_fill_data (i_imem_rdata),
        .i_pop       (w_pop),
        .o_alloc     (w_alloc),
        .o_owed      (w_owed),
        .o_full      (w_full),
        .o_valid     (w_ring_valid),
        .o_head_pc   (o_inst_pc),
        .o_head_data (o_inst_data)
    );

    // On redirect every request still owed by memory becomes a response to discard.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_run      <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= PTR_W'(ZeroWord);
        end else begin
            r_run <= 1'b1;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_drop_cnt <= r_drop_cnt + w_owed - PTR_W'(i_imem_rvalid);
            end else begin
                if (w_issue)
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(STEP);
                if (i_imem_rvalid && r_drop_cnt != '0)
                    r_drop_cnt <= r_drop_cnt - PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst != RstEnable && i_imem_rvalid)
            assert (w_owed_total != '0)
            else $error("pc_fetch_queue: imem_rvalid with no outstanding request");
    end

endmodule
